// File: rtl/alu_step_sequencer_if.sv
// Handshake and datapath-strobe bundle between the step sequencer and its datapath/requester.
interface alu_step_sequencer_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned NREG   = 16
);
   logic              start;
   logic              continuous;
   logic              mem_ready;
   logic [DATA_W-1:0] ir;

   logic              pc_out;
   logic              mar_in;
   logic              inc_pc;
   logic              zlow_in;
   logic              zlow_out;
   logic              pc_in;
   logic              read;
   logic              mdr_in;
   logic              mdr_out;
   logic              ir_in;
   logic              y_in;
   logic [NREG-1:0]   reg_out;
   logic [NREG-1:0]   reg_in;
   logic [4:0]        alu_op;
   logic              busy;
   logic              done;
   logic              err;
   logic [2:0]        step;

   // Requester/datapath side: issues commands, observes strobes.
   modport master (
      output start, continuous, mem_ready, ir,
      input  pc_out, mar_in, inc_pc, zlow_in, zlow_out, pc_in, read, mdr_in, mdr_out,
             ir_in, y_in, reg_out, reg_in, alu_op, busy, done, err, step
   );

   // Sequencer side.
   modport slave (
      input  start, continuous, mem_ready, ir,
      output pc_out, mar_in, inc_pc, zlow_in, zlow_out, pc_in, read, mdr_in, mdr_out,
             ir_in, y_in, reg_out, reg_in, alu_op, busy, done, err, step
   );
endinterface

// File: rtl/alu_step_sequencer.sv
// Fetch/execute step sequencer for a three-register ALU instruction:
// IDLE -> T0 (fetch addr) -> T1 (memory wait) -> T2 (IR load) -> T3/T4 (operands) -> T5 (writeback).
module alu_step_sequencer #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned NREG        = 16,
   parameter int unsigned LAST_ALU_OP = 11,
   parameter int unsigned WAIT_MAX    = 15
) (
   input logic                 clock,
   input logic                 clear,
   alu_step_sequencer_if.slave bus
);
   localparam int unsigned RW = (NREG > 1) ? $clog2(NREG) : 1;
   localparam int unsigned WW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_T0   = 3'd1,
      S_T1   = 3'd2,
      S_T2   = 3'd3,
      S_T3   = 3'd4,
      S_T4   = 3'd5,
      S_T5   = 3'd6,
      S_ERR  = 3'd7
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [WW-1:0]   r_wait;

   logic [4:0]      w_opcode;
   logic [RW-1:0]   w_ra;
   logic [RW-1:0]   w_rb;
   logic [RW-1:0]   w_rc;
   logic            w_bad_op;
   logic            w_wait_max;
   logic [NREG-1:0] w_ra_hot;
   logic [NREG-1:0] w_rb_hot;
   logic [NREG-1:0] w_rc_hot;
   logic            w_unused_ir;

   assign w_opcode    = bus.ir[DATA_W-1 -: 5];
   assign w_ra        = bus.ir[DATA_W-6 -: RW];
   assign w_rb        = bus.ir[DATA_W-6-RW -: RW];
   assign w_rc        = bus.ir[DATA_W-6-2*RW -: RW];
   assign w_bad_op    = (32'(w_opcode) > LAST_ALU_OP);
   assign w_wait_max  = (32'(r_wait) == WAIT_MAX);
   assign w_unused_ir = ^bus.ir;

   // Register-field decoders; an index at or above NREG simply selects nothing.
   always_comb begin
      w_ra_hot = '0;
      w_rb_hot = '0;
      w_rc_hot = '0;
      for (int unsigned i = 0; i < NREG; i++) begin
         w_ra_hot[i] = (32'(w_ra) == i);
         w_rb_hot[i] = (32'(w_rb) == i);
         w_rc_hot[i] = (32'(w_rc) == i);
      end
   end

   // State register.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // T1 wait counter: counts cycles without mem_ready, zero outside T1 so every T1 entry starts at 0.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear)                                 r_wait <= '0;
      else if (r_state == S_T1 && !bus.mem_ready) r_wait <= r_wait + 1'b1;
      else                                        r_wait <= '0;
   end

   // Next-state logic.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (bus.start) w_next = S_T0;
         S_T0:   w_next = S_T1;
         S_T1: begin
            if (bus.mem_ready)   w_next = S_T2;
            else if (w_wait_max) w_next = S_ERR;
         end
         S_T2:   w_next = S_T3;
         S_T3:   w_next = w_bad_op ? S_ERR : S_T4;
         S_T4:   w_next = S_T5;
         S_T5:   w_next = bus.continuous ? S_T0 : S_IDLE;
         S_ERR:  if (bus.start) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Output decode: Moore on state, except the T1 exit strobes which follow mem_ready.
   always_comb begin
      bus.pc_out   = 1'b0;
      bus.mar_in   = 1'b0;
      bus.inc_pc   = 1'b0;
      bus.zlow_in  = 1'b0;
      bus.zlow_out = 1'b0;
      bus.pc_in    = 1'b0;
      bus.read     = 1'b0;
      bus.mdr_in   = 1'b0;
      bus.mdr_out  = 1'b0;
      bus.ir_in    = 1'b0;
      bus.y_in     = 1'b0;
      bus.reg_out  = '0;
      bus.reg_in   = '0;
      bus.alu_op   = '0;
      bus.done     = 1'b0;
      bus.err      = (r_state == S_ERR);
      bus.busy     = (r_state != S_IDLE) && (r_state != S_ERR);
      bus.step     = r_state;
      case (r_state)
         S_T0: begin
            bus.pc_out  = 1'b1;
            bus.mar_in  = 1'b1;
            bus.inc_pc  = 1'b1;
            bus.zlow_in = 1'b1;
         end
         S_T1: begin
            bus.read     = 1'b1;
            bus.mdr_in   = 1'b1;
            bus.zlow_out = bus.mem_ready;
            bus.pc_in    = bus.mem_ready;
         end
         S_T2: begin
            bus.mdr_out = 1'b1;
            bus.ir_in   = 1'b1;
         end
         S_T3: begin
            if (!w_bad_op) begin
               bus.reg_out = w_rb_hot;
               bus.y_in    = 1'b1;
            end
         end
         S_T4: begin
            bus.reg_out = w_rc_hot;
            bus.zlow_in = 1'b1;
            bus.alu_op  = w_opcode;
         end
         S_T5: begin
            bus.zlow_out = 1'b1;
            bus.reg_in   = w_ra_hot;
            bus.done     = 1'b1;
         end
         default: ;
      endcase
   end
endmodule

// File: doc/alu_step_sequencer.md
ALU_STEP_SEQUENCER -- requirements
Module: alu_step_sequencer

Parameters
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the IR width.
REQ-002 The block SHALL have parameter NREG, default 16, giving the register count; RW = clog2(NREG).
REQ-003 The block SHALL have parameter LAST_ALU_OP, default 11, giving the highest legal opcode.
REQ-004 The block SHALL have parameter WAIT_MAX, default 15, giving the maximum T1 wait cycles before an error.

Interface
REQ-005 clock  in  1  sole clock; all state changes on rising edge.
REQ-006 clear  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  request one instruction cycle; sampled in IDLE only.
REQ-008 continuous  in  1  sampled in T5; when high, chain directly into the next fetch.
REQ-009 mem_ready  in  1  memory read complete; sampled in T1.
REQ-010 ir  in  DATA_W  IR contents; opcode = ir[DATA_W-1 -: 5], Ra = next RW bits below it, Rb = next RW bits, Rc = next RW bits.
REQ-011 pc_out, mar_in, inc_pc, zlow_in, zlow_out, pc_in, read, mdr_in, mdr_out, ir_in, y_in  out  1 each  datapath strobes.
REQ-012 reg_out  out  NREG  one-hot register-to-bus enable.
REQ-013 reg_in  out  NREG  one-hot register load enable.
REQ-014 alu_op  out  5  ALU function select.
REQ-015 busy  out  1  high in every state except IDLE and ERR.
REQ-016 done  out  1  one-cycle pulse on completion.
REQ-017 err  out  1  high while in ERR.
REQ-018 step  out  3  state code: IDLE=0, T0..T5=1..6, ERR=7.

Function
REQ-019 All outputs SHALL be Moore functions of state, except the T1 exit strobes (REQ-022), which also depend on mem_ready.
REQ-020 IDLE: all strobes low; start=1 -> T0 on the next edge; start=0 -> remain in IDLE.
REQ-021 T0, one cycle: pc_out, mar_in, inc_pc, zlow_in high -> T1.
REQ-022 T1: read and mdr_in high every cycle. In the cycle mem_ready=1, zlow_out and pc_in are also high for that single cycle, then -> T2.
REQ-023 T1 wait counter: starts at 0 on T1 entry and increments each cycle with mem_ready=0. When it reaches WAIT_MAX with mem_ready still 0 -> ERR; pc_in is never asserted on this path.
REQ-024 T2, one cycle: mdr_out, ir_in high -> T3.
REQ-025 T3: opcode > LAST_ALU_OP -> ERR with no strobes asserted in T3. Otherwise reg_out[Rb] and y_in are high -> T4.
REQ-026 T4, one cycle: reg_out[Rc] and zlow_in high; alu_op = opcode -> T5.
REQ-027 alu_op SHALL be 0 in every state other than T4.
REQ-028 T5, one cycle: zlow_out and reg_in[Ra] high.
REQ-029 T5 exit: continuous=1 -> T0; otherwise done=1 for one cycle and -> IDLE.
REQ-030 T5 exit with continuous=1 (chained): done=1 in the T5 cycle; no IDLE cycle is inserted.
REQ-031 done SHALL be asserted in the T5 cycle in both cases.
REQ-032 A field index >= NREG SHALL assert no reg_out/reg_in bit and is not an error.
REQ-033 ERR: err=1, all strobes low. Leave only when start=1, going to IDLE on that edge; that start does not launch a fetch.
REQ-034 start while busy=1 SHALL be ignored and not queued.
REQ-035 At most one reg_out bit and at most one reg_in bit SHALL be high in any cycle.

Reset
REQ-036 clear=0 SHALL force IDLE asynchronously, from any state including mid-T1 wait.
REQ-037 Under reset, every output SHALL be 0, step=0, and the wait counter SHALL be cleared.
REQ-038 Release is synchronous to clock; the first start is honoured on the first edge after clear=1.

Verification
REQ-039 ir=0x28918000, mem_ready=1, start pulse: step 1..6 over consecutive cycles; T3 reg_out=0x0004; T4 reg_out=0x0008, alu_op=5'b00101; T5 reg_in=0x0002; done=1 in T5.
REQ-040 Same ir, mem_ready low for 3 cycles: T1 lasts 4 cycles; pc_in high exactly once, in the 4th cycle; total latency 9 cycles.
REQ-041 mem_ready held 0: ERR reached after WAIT_MAX+1 T1 cycles with err=1. A start pulse then returns to IDLE, with no T0 in the following cycle.
REQ-042 ir opcode=5'b11111: ERR entered from T3; reg_out and y_in never asserted.
REQ-043 continuous=1 across two instructions: T5 is followed directly by T0 (step 6 -> 1); done pulses once per instruction.
REQ-044 clear=0 asserted mid-T1, then released: all outputs 0 immediately; next start yields a full, correct sequence.
